// File: rtl/ad_bus_arbiter.sv
// ----------------------------------------------------------------------------
// ad_bus_arbiter
//   Round-robin arbiter/sequencer for a shared 32-bit tri-state `ad` bus.
//   Each requester drives `ad` through its own bufif0 bank. This block grants
//   the bus to one requester at a time and produces the active-low enables.
//   Between owners it inserts TA_CYCLES cycles with every driver released, so
//   two banks never contend. An owner that holds the bus while others wait is
//   forced off after MAX_HOLD cycles.
//
// Ports
//   clk        : clock
//   reset      : asynchronous, active-high reset
//   req_i      : per-requester bus request, level-sensitive
//   done_i     : per-requester release strobe; only the owner's bit counts
//   gnt_o      : one-hot grant, registered
//   drv_n_o    : bufif0 controls (0 = drive `ad`), always ~gnt_o
//   owner_o    : index of the current or most recent owner
//   busy_o     : high whenever the arbiter is not idle
//   timeout_o  : one-cycle pulse when the owner is forced off by MAX_HOLD
// ----------------------------------------------------------------------------
module ad_bus_arbiter #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned MAX_HOLD  = 8,
   parameter int unsigned TA_CYCLES = 1
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [NREQ-1:0]                          req_i,
   input  logic [NREQ-1:0]                          done_i,
   output logic [NREQ-1:0]                          gnt_o,
   output logic [NREQ-1:0]                          drv_n_o,
   output logic [((NREQ > 2) ? $clog2(NREQ) : 1)-1:0] owner_o,
   output logic                                     busy_o,
   output logic                                     timeout_o
);

   localparam int unsigned IW = (NREQ > 2) ? $clog2(NREQ) : 1;

   localparam logic [IW-1:0] IDX_ONE   = IW'(1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NREQ - 1);
   localparam logic [7:0]    HOLD_MAX  = 8'(MAX_HOLD);
   localparam logic [7:0]    HOLD_LAST = 8'(MAX_HOLD - 1);
   localparam logic [2:0]    TA_LAST   = 3'(TA_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TURN  = 2'd2
   } state_t;

   // First set bit of r scanning p, p+1, ... modulo NREQ.
   function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IW-1:0]   p);
      logic [IW-1:0] win;
      logic [IW:0]   idx;
      logic          found;
      win   = p;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         idx = {1'b0, p} + (IW+1)'(i);
         if (idx >= (IW+1)'(NREQ)) begin
            idx = idx - (IW+1)'(NREQ);
         end else begin
            idx = idx;
         end
         if (!found && r[idx[IW-1:0]]) begin
            win   = idx[IW-1:0];
            found = 1'b1;
         end else begin
            found = found;
         end
      end
      return win;
   endfunction

   // One-hot vector with bit i set.
   function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
      logic [NREQ-1:0] v;
      v    = {NREQ{1'b0}};
      v[i] = 1'b1;
      return v;
   endfunction

   state_t          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] drv_n_q, drv_n_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [7:0]      hold_q, hold_d;
   logic [2:0]      ta_q, ta_d;
   logic            busy_q, busy_d;
   logic            timeout_q, timeout_d;

   logic [IW-1:0]   win_s;
   logic            any_req_s;
   logic            others_s;
   logic            vol_rel_s;
   logic            force_rel_s;

   // Arbitration and release terms used by the next-state logic.
   always_comb begin
      win_s       = rr_pick(req_i, ptr_q);
      any_req_s   = |req_i;
      others_s    = |(req_i & ~gnt_q);
      // Voluntary release: owner strobes done or drops its request.
      vol_rel_s   = done_i[owner_q] | ~req_i[owner_q];
      // Forced release once the hold budget is spent while others wait; the
      // >= also covers an owner that reached saturation before anyone else
      // started requesting, so a late requester is not locked out.
      force_rel_s = (hold_q >= HOLD_LAST) & others_s;
   end

   // Next-state and next-output computation for the arbiter FSM.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      ta_d      = ta_q;
      timeout_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (any_req_s) begin
               gnt_d   = onehot(win_s);
               owner_d = win_s;
               hold_d  = 8'd0;
               state_d = ST_GRANT;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_GRANT: begin
            if (vol_rel_s || force_rel_s) begin
               gnt_d     = {NREQ{1'b0}};
               ptr_d     = (owner_q == IDX_LAST) ? {IW{1'b0}} : (owner_q + IDX_ONE);
               ta_d      = 3'd0;
               state_d   = ST_TURN;
               // Only flag a timeout when the owner did not leave on its own.
               timeout_d = force_rel_s & ~vol_rel_s;
            end else begin
               state_d = ST_GRANT;
            end
            if (hold_q != HOLD_MAX) begin
               hold_d = hold_q + 8'd1;
            end else begin
               hold_d = hold_q;
            end
         end

         ST_TURN: begin
            if (ta_q == TA_LAST) begin
               // ptr_q already points past the releasing owner, giving it
               // lowest priority in this arbitration.
               if (any_req_s) begin
                  gnt_d   = onehot(win_s);
                  owner_d = win_s;
                  hold_d  = 8'd0;
                  state_d = ST_GRANT;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               ta_d    = ta_q + 3'd1;
               state_d = ST_TURN;
            end
         end

         default: begin
            gnt_d   = {NREQ{1'b0}};
            state_d = ST_IDLE;
         end
      endcase

      drv_n_d = ~gnt_d;
      busy_d  = (state_d != ST_IDLE);
   end

   // State and registered outputs; reset releases every driver immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         gnt_q     <= {NREQ{1'b0}};
         drv_n_q   <= {NREQ{1'b1}};
         owner_q   <= {IW{1'b0}};
         ptr_q     <= {IW{1'b0}};
         hold_q    <= 8'd0;
         ta_q      <= 3'd0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         drv_n_q   <= drv_n_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         ta_q      <= ta_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign gnt_o     = gnt_q;
   assign drv_n_o   = drv_n_q;
   assign owner_o   = owner_q;
   assign busy_o    = busy_q;
   assign timeout_o = timeout_q;

   ad_bus_arbiter_chk #(
      .NREQ (NREQ)
   ) u_chk (
      .clk        (clk),
      .reset      (reset),
      .gnt_i      (gnt_q),
      .drv_n_i    (drv_n_q),
      .in_grant_i (state_q == ST_GRANT)
   );

endmodule

// ----------------------------------------------------------------------------
// ad_bus_arbiter_chk
//   Bus-safety invariants of the arbiter outputs.
//
// Ports
//   clk        : clock
//   reset      : asynchronous, active-high reset
//   gnt_i      : grant vector
//   drv_n_i    : bufif0 controls
//   in_grant_i : arbiter is in its GRANT state
// ----------------------------------------------------------------------------
module ad_bus_arbiter_chk #(
   parameter int unsigned NREQ = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] gnt_i,
   input  logic [NREQ-1:0] drv_n_i,
   input  logic            in_grant_i
);

   a_gnt_onehot0 : assert property (@(posedge clk) disable iff (reset)
      $onehot0(gnt_i));

   a_drv_inverse : assert property (@(posedge clk) disable iff (reset)
      drv_n_i == ~gnt_i);

   a_gnt_in_grant : assert property (@(posedge clk) disable iff (reset)
      (gnt_i != {NREQ{1'b0}}) |-> in_grant_i);

   // A new owner may only appear after an all-released cycle.
   a_no_direct_switch : assert property (@(posedge clk) disable iff (reset)
      (($past(gnt_i) != {NREQ{1'b0}}) && (gnt_i != {NREQ{1'b0}}))
         |-> (gnt_i == $past(gnt_i)));

endmodule

// File: tb/tb_ad_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ad_bus_arbiter
//   Directed bench for ad_bus_arbiter (NREQ=4, MAX_HOLD=8, TA_CYCLES=1).
//   Inputs change 1 time unit after a rising edge; the expectation for the
//   following edge is queued at that moment and compared 1 unit after it.
// ----------------------------------------------------------------------------
module tb_ad_bus_arbiter;

   logic       clk;
   logic       reset;
   logic [3:0] req;
   logic [3:0] done;
   logic [3:0] gnt;
   logic [3:0] drv_n;
   logic [1:0] owner;
   logic       busy;
   logic       timeout;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      string      tag;
      logic [3:0] gnt;
      logic [1:0] owner;
      logic       busy;
      logic       tmo;
   } exp_t;

   exp_t exp_q[$];

   ad_bus_arbiter #(
      .NREQ      (4),
      .MAX_HOLD  (8),
      .TA_CYCLES (1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_i     (req),
      .done_i    (done),
      .gnt_o     (gnt),
      .drv_n_o   (drv_n),
      .owner_o   (owner),
      .busy_o    (busy),
      .timeout_o (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic push(input string tag, input logic [3:0] g, input logic [1:0] o,
                       input logic b, input logic t);
      exp_t e;
      e.tag   = tag;
      e.gnt   = g;
      e.owner = o;
      e.busy  = b;
      e.tmo   = t;
      exp_q.push_back(e);
   endtask

   task automatic cmp_now();
      exp_t e;
      logic [3:0] want_drv;
      e = exp_q.pop_front();
      want_drv = ~e.gnt;
      n_cmp++;
      assert (gnt === e.gnt) else begin
         n_fail++;
         $error("FAIL %s gnt: got %b want %b", e.tag, gnt, e.gnt);
      end
      n_cmp++;
      assert (drv_n === want_drv) else begin
         n_fail++;
         $error("FAIL %s drv_n: got %b want %b", e.tag, drv_n, want_drv);
      end
      n_cmp++;
      assert (owner === e.owner) else begin
         n_fail++;
         $error("FAIL %s owner: got %0d want %0d", e.tag, owner, e.owner);
      end
      n_cmp++;
      assert (busy === e.busy) else begin
         n_fail++;
         $error("FAIL %s busy: got %b want %b", e.tag, busy, e.busy);
      end
      n_cmp++;
      assert (timeout === e.tmo) else begin
         n_fail++;
         $error("FAIL %s timeout: got %b want %b", e.tag, timeout, e.tmo);
      end
   endtask

   // Drive req/done for the next edge, queue the expectation, then compare.
   task automatic cyc(input string tag, input logic [3:0] r, input logic [3:0] d,
                      input logic [3:0] g, input logic [1:0] o,
                      input logic b, input logic t);
      req  = r;
      done = d;
      push(tag, g, o, b, t);
      @(posedge clk);
      #1;
      cmp_now();
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      req   = 4'b0000;
      done  = 4'b0000;
      @(posedge clk);
      #1;
      push(tag, 4'b0000, 2'd0, 1'b0, 1'b0);
      cmp_now();
      reset = 1'b0;
   endtask

   initial begin
      logic [3:0] oh;
      reset = 1'b1;
      req   = 4'b0000;
      done  = 4'b0000;

      // 1: single grant, release by dropping req, back to idle
      do_reset("reset0");
      cyc("t1 grant", 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
      cyc("t1 hold",  4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
      cyc("t1 rel",   4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0);
      cyc("t1 idle",  4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
      cyc("t1 idle2", 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

      // 2: all requesting, done after 2 cycles -> order 0,1,2,3,0
      do_reset("reset2");
      for (int k = 0; k < 5; k++) begin
         oh = 4'b0001 << (k % 4);
         cyc("t2 grant", 4'b1111, 4'b0000, oh, 2'(k % 4), 1'b1, 1'b0);
         cyc("t2 hold",  4'b1111, 4'b0000, oh, 2'(k % 4), 1'b1, 1'b0);
         cyc("t2 gap",   4'b1111, oh,      4'b0000, 2'(k % 4), 1'b1, 1'b0);
      end
      cyc("t2 idle", 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

      // 3: owner 0 never releases; forced off after 8 cycles
      do_reset("reset3");
      cyc("t3 grant", 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
      for (int k = 0; k < 7; k++) begin
         cyc("t3 hold", 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
      end
      cyc("t3 force", 4'b0011, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b1);
      cyc("t3 next",  4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);

      // 4: sole requester keeps the bus past MAX_HOLD without timeout
      for (int k = 0; k < 20; k++) begin
         cyc("t4 hold", 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
      end
      cyc("t4 rel",  4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0);
      cyc("t4 idle", 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);

      // 5: non-owner done ignored; owner done releases; ptr=3 next
      cyc("t5 grant", 4'b1101, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
      cyc("t5 d0",    4'b1101, 4'b0001, 4'b0100, 2'd2, 1'b1, 1'b0);
      cyc("t5 d3",    4'b1101, 4'b1000, 4'b0100, 2'd2, 1'b1, 1'b0);
      cyc("t5 d03",   4'b1101, 4'b1001, 4'b0100, 2'd2, 1'b1, 1'b0);
      cyc("t5 d2",    4'b1101, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0);
      cyc("t5 next",  4'b1101, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0);
      cyc("t5 both",  4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0);
      cyc("t5 idle",  4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);
      cyc("t5 idle d", 4'b0000, 4'b1111, 4'b0000, 2'd3, 1'b0, 1'b0);

      // 6: async reset mid-grant, then ptr back at 0
      cyc("t6 grant", 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
      cyc("t6 hold",  4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
      #3;
      reset = 1'b1;
      #1;
      push("t6 async", 4'b0000, 2'd0, 1'b0, 1'b0);
      cmp_now();
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc("t6 regrant", 4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
      cyc("t6 rel",     4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0);
      cyc("t6 idle",    4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
